muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide execution unit. It sits directly downstream of the register file.
- It consumes the two register read operands and a destination index. It produces a 32-bit result and index, which feed back into the register-file write port (WD3/A3) via writeback.
- It uses a start/busy/done handshake so the controller can stall the core during multi-cycle operations.

---
 rtl/muldiv_pkg.sv | 33 +++
 rtl/muldiv_step.sv | 36 +++
 rtl/muldiv_unit.sv | 176 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants for the RV32M multiply/divide unit.
//   - RV32M funct3 encodings (F3_MUL..F3_REMU)
//   - FSM state encoding (S_IDLE..S_DONE)
//   - default operand width
//   - fixed results for divide-by-zero and signed overflow
package muldiv_pkg;

   localparam int XLEN_DEF = 32;

   localparam logic [2:0] F3_MUL    = 3'd0;
   localparam logic [2:0] F3_MULH   = 3'd1;
   localparam logic [2:0] F3_MULHSU = 3'd2;
   localparam logic [2:0] F3_MULHU  = 3'd3;
   localparam logic [2:0] F3_DIV    = 3'd4;
   localparam logic [2:0] F3_DIVU   = 3'd5;
   localparam logic [2:0] F3_REM    = 3'd6;
   localparam logic [2:0] F3_REMU   = 3'd7;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [31:0] DIV_ZERO_QUO = 32'hFFFF_FFFF;
   localparam logic [31:0] OVF_QUO      = 32'h8000_0000;
   localparam logic [31:0] OVF_REM      = 32'h0000_0000;

   // funct3[2] separates the divide group from the multiply group.
   function automatic logic is_div_op(input logic [2:0] f3);
      return f3[2];
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 iteration of the shared 2*XLEN accumulator.
//   is_div  in  : 0 = shift-add multiply step, 1 = restoring divide step
//   acc_i   in  : accumulator before the step
//   b_i     in  : multiplicand / divisor magnitude
//   acc_o   out : accumulator after the step
// Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
// Divide:   acc = {remainder, dividend/quotient bits}, shifted left; after
//           XLEN steps the upper half is the remainder, the lower the quotient.
module muldiv_step #(
   parameter int XLEN = 32
) (
   input  logic              is_div,
   input  logic [2*XLEN-1:0] acc_i,
   input  logic [XLEN-1:0]   b_i,
   output logic [2*XLEN-1:0] acc_o
);

   logic [XLEN:0] sum;
   logic [XLEN:0] hi_sh;
   logic [XLEN:0] diff;

   always_comb begin
      sum   = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, b_i} : '0);
      // Remainder < divisor, so the shifted trial value always fits XLEN+1 bits
      // and diff's top bit is a reliable borrow.
      hi_sh = acc_i[2*XLEN-1:XLEN-1];
      diff  = hi_sh - {1'b0, b_i};
      if (is_div) begin
         if (!diff[XLEN]) acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
         else             acc_o = {hi_sh[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
      end else begin
         acc_o = {sum, acc_i[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit with start/busy/done.
//   clk, rst (async, active-high)
//   start   in  : request, accepted in IDLE only
//   funct3  in  : RV32M operation
//   op_a    in  : rs1 value
//   op_b    in  : rs2 value
//   rd_in   in  : destination register index
//   busy    out : operation in progress
//   done    out : one-cycle pulse, result/rd_out valid
//   result  out : result, held until overwritten by the next operation
//   rd_out  out : rd_in latched at start
// Build option MULDIV_FAST_MUL_EN: multiplies finish in a single RUN cycle
// using a combinational 64-bit product; divides are unchanged.
//
// state  | meaning
// IDLE   | waiting for start
// RUN    | one iteration per cycle (XLEN cycles)
// FIX    | sign correction and special cases, result registered
// DONE   | done pulse, return to IDLE
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic [4:0]      rd_in,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_out
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        f3_q, f3_d;
   logic [4:0]        rd_q, rd_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   b_q, b_d;
   logic              neg_q, neg_d;
   logic              bz_q, bz_d;
   logic              ovf_q, ovf_d;
   logic [XLEN-1:0]   result_q, result_d;

   logic              sgn_a, sgn_b;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic [2*XLEN-1:0] step_acc;
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   div_v, div_s, fix_res;

   muldiv_step #(.XLEN(XLEN)) u_step (
      .is_div (is_div_op(f3_q)),
      .acc_i  (acc_q),
      .b_i    (b_q),
      .acc_o  (step_acc)
   );

`ifdef MULDIV_FAST_MUL_EN
   logic [2*XLEN-1:0] fast_prod;
   assign fast_prod = {{XLEN{1'b0}}, acc_q[XLEN-1:0]} * {{XLEN{1'b0}}, b_q};
`endif

   // Operand conditioning at start: which operands are read as signed.
   always_comb begin
      sgn_a = op_a[XLEN-1] & (funct3 == F3_MULH || funct3 == F3_MULHSU ||
                              funct3 == F3_DIV  || funct3 == F3_REM);
      sgn_b = op_b[XLEN-1] & (funct3 == F3_MULH || funct3 == F3_DIV ||
                              funct3 == F3_REM);
      mag_a = sgn_a ? -op_a : op_a;
      mag_b = sgn_b ? -op_b : op_b;
   end

   // Sign correction and special-case selection, used in FIX.
   always_comb begin
      prod_s = neg_q ? -acc_q : acc_q;
      div_v  = f3_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
      div_s  = neg_q ? -div_v : div_v;
      if (!is_div_op(f3_q)) begin
         fix_res = (f3_q == F3_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
      end else if (ovf_q) begin
         fix_res = f3_q[1] ? OVF_REM : OVF_QUO;
      end else if (bz_q && !f3_q[1]) begin
         fix_res = DIV_ZERO_QUO;
      end else begin
         // Remainder by zero falls out of the iteration as |a| with the
         // dividend's sign restored, i.e. op_a itself.
         fix_res = div_s;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      f3_d     = f3_q;
      rd_d     = rd_q;
      acc_d    = acc_q;
      b_d      = b_q;
      neg_d    = neg_q;
      bz_d     = bz_q;
      ovf_d    = ovf_q;
      result_d = result_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               f3_d    = funct3;
               rd_d    = rd_in;
               acc_d   = {{XLEN{1'b0}}, mag_a};
               b_d     = mag_b;
               neg_d   = (funct3 == F3_REM) ? sgn_a : (sgn_a ^ sgn_b);
               bz_d    = (op_b == '0);
               ovf_d   = (funct3 == F3_DIV || funct3 == F3_REM) &&
                         (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            acc_d = step_acc;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) state_d = S_FIX;
`ifdef MULDIV_FAST_MUL_EN
            if (!is_div_op(f3_q)) begin
               acc_d   = fast_prod;
               state_d = S_FIX;
            end
`endif
         end
         S_FIX: begin
            result_d = fix_res;
            state_d  = S_DONE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         f3_q     <= '0;
         rd_q     <= '0;
         acc_q    <= '0;
         b_q      <= '0;
         neg_q    <= 1'b0;
         bz_q     <= 1'b0;
         ovf_q    <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         f3_q     <= f3_d;
         rd_q     <= rd_d;
         acc_q    <= acc_d;
         b_q      <= b_d;
         neg_q    <= neg_d;
         bz_q     <= bz_d;
         ovf_q    <= ovf_d;
         result_q <= result_d;
      end
   end

   assign busy   = (state_q == S_RUN) || (state_q == S_FIX);
   assign done   = (state_q == S_DONE);
   assign result = result_q;
   assign rd_out = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit. Cycle 1 is the cycle right after the edge that
// accepts start; done is expected in cycle 34 (cycle 3 for multiplies when
// MULDIV_FAST_MUL_EN is defined), busy in every cycle before that.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] op_a, op_b;
   logic [4:0]  rd_in;
   logic        busy, done;
   logic [31:0] result;
   logic [4:0]  rd_out;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   muldiv_unit dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .funct3 (funct3),
      .op_a   (op_a),
      .op_b   (op_b),
      .rd_in  (rd_in),
      .busy   (busy),
      .done   (done),
      .result (result),
      .rd_out (rd_out)
   );

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[17];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic int exp_lat(input logic [2:0] f3);
`ifdef MULDIV_FAST_MUL_EN
      return f3[2] ? 34 : 3;
`else
      return 34;
`endif
   endfunction

   // Called in cycle 1 of an operation (#1 after the accepting edge).
   task automatic wait_done(input bit hold, output int lat, output int bcnt);
      lat  = 0;
      bcnt = 0;
      for (int c = 1; c <= 60; c++) begin
         if (busy) bcnt++;
         if (done) begin
            lat = c;
            break;
         end
         if (hold) begin
            op_a   = $urandom;
            op_b   = $urandom;
            funct3 = 3'($urandom_range(0, 7));
            rd_in  = 5'($urandom_range(0, 31));
         end
         @(posedge clk); #1;
      end
      if (lat == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL done_timeout: got no done within 60 cycles");
      end
   endtask

   task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input bit hold,
                         input logic [31:0] exp);
      int lat, bcnt;
      start  = 1'b1;
      funct3 = f3;
      op_a   = a;
      op_b   = b;
      rd_in  = rd;
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      wait_done(hold, lat, bcnt);
      start = 1'b0;
      check({name, "_result"}, result, exp);
      check({name, "_rd"}, {27'b0, rd_out}, {27'b0, rd});
      check({name, "_latency"}, 32'(lat), 32'(exp_lat(f3)));
      check({name, "_busy_cycles"}, 32'(bcnt), 32'(exp_lat(f3) - 1));
      @(posedge clk); #1;
      check({name, "_done_pulse"}, {31'b0, done}, 32'd0);
   endtask

   initial begin
      int lat, bcnt, dcnt;

      vecs[0]  = '{F3_MUL,    32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB};
      vecs[1]  = '{F3_MULH,   32'h8000_0000,  32'h8000_0000, 5'd1,  32'h4000_0000};
      vecs[2]  = '{F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE};
      vecs[3]  = '{F3_MULHSU, 32'hFFFF_FFFF,  32'd2,         5'd3,  32'hFFFF_FFFF};
      vecs[4]  = '{F3_DIV,    32'hFFFF_FFEC,  32'd6,         5'd4,  32'hFFFF_FFFD};
      vecs[5]  = '{F3_REM,    32'hFFFF_FFEC,  32'd6,         5'd6,  32'hFFFF_FFFE};
      vecs[6]  = '{F3_DIVU,   32'd20,         32'd6,         5'd7,  32'd3};
      vecs[7]  = '{F3_REMU,   32'd20,         32'd6,         5'd8,  32'd2};
      vecs[8]  = '{F3_DIVU,   32'd123,        32'd0,         5'd9,  32'hFFFF_FFFF};
      vecs[9]  = '{F3_REM,    32'd123,        32'd0,         5'd10, 32'd123};
      vecs[10] = '{F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h8000_0000};
      vecs[11] = '{F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'd0};
      vecs[12] = '{F3_DIV,    32'hFFFF_FFEC,  32'd0,         5'd13, 32'hFFFF_FFFF};
      vecs[13] = '{F3_REMU,   32'hFFFF_FFEC,  32'd0,         5'd14, 32'hFFFF_FFEC};
      vecs[14] = '{F3_MULH,   32'hFFFF_FFFD,  32'd7,         5'd15, 32'hFFFF_FFFF};
      vecs[15] = '{F3_DIV,    32'd7,          32'hFFFF_FFFE, 5'd16, 32'hFFFF_FFFD};
      vecs[16] = '{F3_MULHU,  32'h1234_5678,  32'h0000_0010, 5'd31, 32'd1};

      rst    = 1'b1;
      start  = 1'b0;
      funct3 = '0;
      op_a   = '0;
      op_b   = '0;
      rd_in  = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_busy",   {31'b0, busy}, 32'd0);
      check("reset_done",   {31'b0, done}, 32'd0);
      check("reset_result", result, 32'd0);
      check("reset_rd",     {27'b0, rd_out}, 32'd0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;

      // Consecutive table entries also start in the IDLE cycle right after DONE.
      for (int i = 0; i < 17; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b,
                vecs[i].rd, 1'b0, vecs[i].exp);
      end

      // A start presented in DONE is ignored, then taken on the next IDLE edge.
      start = 1'b1; funct3 = F3_DIVU; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd3;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(1'b0, lat, bcnt);
      check("b2b_first_result", result, 32'd14);
      start = 1'b1; funct3 = F3_MUL; op_a = 32'd6; op_b = 32'd7; rd_in = 5'd4;
      @(posedge clk); #1;
      check("start_in_done_busy", {31'b0, busy}, 32'd0);
      check("start_in_done_held", result, 32'd14);
      @(posedge clk); #1;
      start = 1'b0;
      check("b2b_accept_busy", {31'b0, busy}, 32'd1);
      wait_done(1'b0, lat, bcnt);
      check("b2b_second_result", result, 32'd42);
      check("b2b_second_rd", {27'b0, rd_out}, 32'd4);
      check("b2b_second_latency", 32'(lat), 32'(exp_lat(F3_MUL)));
      @(posedge clk); #1;

      // Reset in cycle 10 of a divide aborts it without a done pulse.
      start = 1'b1; funct3 = F3_DIV; op_a = 32'hFFFF_FFEC; op_b = 32'd6; rd_in = 5'd7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      #1;
      check("abort_busy",   {31'b0, busy}, 32'd0);
      check("abort_done",   {31'b0, done}, 32'd0);
      check("abort_result", result, 32'd0);
      check("abort_rd",     {27'b0, rd_out}, 32'd0);
      @(negedge clk) rst = 1'b0;
      dcnt = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (done) dcnt++;
      end
      check("abort_no_done", 32'(dcnt), 32'd0);
      run_op("after_abort_mul", F3_MUL, 32'd3, 32'd4, 5'd2, 1'b0, 32'd12);

      // start held high while operands and funct3 wander during RUN.
      run_op("hold_mul", F3_MUL, 32'd3, 32'd4, 5'd9, 1'b1, 32'd12);
      run_op("hold_div", F3_DIVU, 32'd1000, 32'd9, 5'd17, 1'b1, 32'd111);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
